// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory initiator and data_ram: op encodings,
// FSM state constants and the RAM control constants.
package mem_access_ctrl_pkg;

    localparam logic [2:0] MEM_OP_LB  = 3'd0;
    localparam logic [2:0] MEM_OP_LBU = 3'd1;
    localparam logic [2:0] MEM_OP_LH  = 3'd2;
    localparam logic [2:0] MEM_OP_LHU = 3'd3;
    localparam logic [2:0] MEM_OP_LW  = 3'd4;
    localparam logic [2:0] MEM_OP_SB  = 3'd5;
    localparam logic [2:0] MEM_OP_SH  = 3'd6;
    localparam logic [2:0] MEM_OP_SW  = 3'd7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic        CHIP_ENABLE   = 1'b1;
    localparam logic        CHIP_DISABLE  = 1'b0;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

    // Latched request payload; the address is kept separately because its width is a parameter.
    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] wdata;
    } req_meta_t;

    function automatic logic op_is_store(input logic [2:0] op);
        return op >= MEM_OP_SB;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response channel from the MEM stage plus the byte-lane RAM port.
// master = pipeline/RAM side, slave = mem_access_ctrl.
interface mem_access_ctrl_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;
    logic              mem_ce_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [3:0]        mem_sel_o;
    logic [31:0]       mem_data_o;
    logic [31:0]       mem_data_i;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_data_i,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_data_i,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o
    );
endinterface

// File: rtl/mem_lane_fmt.sv
// Big-endian byte-lane formatter: lane enables, store replication, load extension, alignment check.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module mem_lane_fmt
    import mem_access_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [3:0]  sel_b;
    logic [3:0]  sel_h;

    always_comb begin
        byte_v = rdata[31:24];
        case (off)
            2'd1:    byte_v = rdata[23:16];
            2'd2:    byte_v = rdata[15:8];
            2'd3:    byte_v = rdata[7:0];
            default: byte_v = rdata[31:24];
        endcase
        half_v = off[1] ? rdata[15:0] : rdata[31:16];
        sel_b  = 4'b1000 >> off;
        sel_h  = off[1] ? 4'b0011 : 4'b1100;
    end

    always_comb begin
        sel        = 4'b1111;
        wdata_rep  = wdata;
        rdata_ext  = ZERO_WORD;
        misaligned = 1'b0;
        case (op)
            MEM_OP_LB:  begin sel = sel_b; rdata_ext = {{24{byte_v[7]}}, byte_v}; end
            MEM_OP_LBU: begin sel = sel_b; rdata_ext = {24'h0, byte_v}; end
            MEM_OP_LH:  begin sel = sel_h; misaligned = off[0]; rdata_ext = {{16{half_v[15]}}, half_v}; end
            MEM_OP_LHU: begin sel = sel_h; misaligned = off[0]; rdata_ext = {16'h0, half_v}; end
            MEM_OP_LW:  begin misaligned = (off != 2'd0); rdata_ext = rdata; end
            MEM_OP_SB:  begin sel = sel_b; wdata_rep = {4{wdata[7:0]}}; end
            MEM_OP_SH:  begin sel = sel_h; misaligned = off[0]; wdata_rep = {2{wdata[15:0]}}; end
            MEM_OP_SW:  begin misaligned = (off != 2'd0); end
            default:    begin sel = 4'b1111; end
        endcase
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory initiator: one load/store in flight, misaligned accesses answered with an error.
// Latency: accept to resp_valid = 2 cycles for stores/errors, 2+RD_LAT for loads.
// Backpressure: req_ready is high only in IDLE; the pipeline stalls for the whole access.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_ctrl_if.slave bus
);
    localparam logic [2:0] LAT_INIT = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

    logic [1:0]        state;
    req_meta_t         req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        cnt;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [3:0]  sel;
    logic [31:0] wdata_rep;
    logic [31:0] rdata_ext;
    logic        misaligned;
    logic        is_store;

    mem_lane_fmt u_fmt (
        .op         (req_q.op),
        .off        (addr_q[1:0]),
        .wdata      (req_q.wdata),
        .rdata      (bus.mem_data_i),
        .sel        (sel),
        .wdata_rep  (wdata_rep),
        .rdata_ext  (rdata_ext),
        .misaligned (misaligned)
    );

    assign is_store = op_is_store(req_q.op);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            req_q   <= '0;
            addr_q  <= '0;
            cnt     <= 3'd0;
            rdata_q <= ZERO_WORD;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        req_q.op    <= bus.req_op;
                        req_q.wdata <= bus.req_wdata;
                        addr_q      <= bus.req_addr;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (misaligned || is_store) begin
                        err_q   <= misaligned;
                        rdata_q <= ZERO_WORD;
                        state   <= ST_RESP;
                    end else if (RD_LAT == 0) begin
                        err_q   <= 1'b0;
                        rdata_q <= rdata_ext;
                        state   <= ST_RESP;
                    end else begin
                        cnt   <= LAT_INIT;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 3'd0) begin
                        err_q   <= 1'b0;
                        rdata_q <= rdata_ext;
                        state   <= ST_RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // RAM port is a pure decode of state so it drops to zero the cycle reset is taken.
    always_comb begin
        bus.mem_ce_o   = CHIP_DISABLE;
        bus.mem_we_o   = WRITE_DISABLE;
        bus.mem_addr_o = '0;
        bus.mem_sel_o  = 4'b0000;
        bus.mem_data_o = ZERO_WORD;
        if ((state == ST_ISSUE && !misaligned) || state == ST_WAIT) begin
            bus.mem_ce_o   = CHIP_ENABLE;
            bus.mem_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
            bus.mem_sel_o  = sel;
        end
        if (state == ST_ISSUE && !misaligned) begin
            bus.mem_we_o   = is_store ? WRITE_ENABLE : WRITE_DISABLE;
            bus.mem_data_o = wdata_rep;
        end
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = (state == ST_RESP);
    assign bus.resp_err   = err_q;
    assign bus.resp_rdata = rdata_q;
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the CPU data-memory interface. Accepts one load/store request at a time from the MEM pipeline stage.
- Drives the byte-lane RAM port (ce/we/addr/sel/data). Waits a configurable read latency, then returns sign-extended or zero-extended load data, or a store completion.
- Detects misaligned accesses and reports them as errors instead of touching memory.
- Sits between the MEM stage and data_ram. Holds the pipeline via req_ready while an access is in flight.

Parameters:
- RD_LAT, 1, number of wait cycles between driving a read and sampling mem_data_i (legal 0..7)
- ADDR_W, 32, request/RAM address width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  MEM stage request valid
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_op  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle pulse: access complete
- resp_err  out  1  valid with resp_valid: misaligned access
- resp_rdata  out  32  extended load data; 0 for stores/errors
- mem_ce_o  out  1  RAM chip enable
- mem_we_o  out  1  RAM write enable
- mem_addr_o  out  ADDR_W  RAM address, word-aligned (low 2 bits forced 0)
- mem_sel_o  out  4  byte-lane enables, sel[3]=bits 31:24
- mem_data_o  out  32  RAM write data
- mem_data_i  in  32  RAM read data

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE. req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0. All mem_* outputs 0. rst overrides any in-flight access; the access is dropped with no response.
- Handshake: accept when req_valid && req_ready at posedge. op/addr/wdata are latched into registers. Inputs are ignored while not IDLE.
- Endianness is big-endian:
  - Byte offset 0→sel 1000, 1→0100, 2→0010, 3→0001.
  - Halfword offset 0→1100, 2→0011.
  - Word→1111.
- Store data is replicated across lanes: SB {4{b}}, SH {2{h}}, SW as-is.
- Alignment: misaligned when LH/LHU/SH has addr[0]=1, or LW/SW has addr[1:0]≠0. Misaligned requests never assert mem_ce_o.
- FSM states:
  - IDLE → ISSUE on accept.
  - ISSUE: drive ce=1, addr, sel, we=is_store, data_o.
    - Store → RESP.
    - Load with RD_LAT=0 → sample mem_data_i this cycle → RESP.
    - Otherwise → WAIT, with counter=RD_LAT-1.
    - Misaligned → RESP with err, and ce stays 0.
  - WAIT: keep ce/addr/sel driven, we=0. At counter=0, sample mem_data_i → RESP; else decrement.
  - RESP: resp_valid=1 for exactly one cycle, mem_* all 0 → IDLE.
- Latency from accept edge to resp_valid:
  - Store: 2 cycles.
  - Misaligned access: 2 cycles.
  - Load: 2+RD_LAT cycles.
  - Next accept is possible the cycle after RESP. Throughput is 1 access per 3+RD_LAT cycles for loads.
- Load extraction: select the lane by the latched addr[1:0]. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- mem_we_o is asserted for exactly one cycle per store. It is never asserted in WAIT.
- resp_rdata and resp_err hold their last value outside resp_valid; the checker must only sample them with resp_valid.

Decomposition:
- Shared package:
  - op encodings (MEM_OP_LB..MEM_OP_SW)
  - FSM state constants
  - ChipEnable/WriteEnable/ZeroWord constants, already shared with data_ram
- One natural sub-module: mem_lane_fmt. It is purely combinational: (op, addr[1:0], wdata, rdata) → (sel, wdata_rep, rdata_ext, misaligned). The FSM and registers stay in mem_access_ctrl.

Test Plan:
- Reset mid-WAIT (RD_LAT=3, LW accepted, rst after 1 cycle): no resp_valid ever; req_ready=1 and mem_ce_o=0 on the cycle after rst.
- SB addr=0x103, wdata=0x000000A5 → one cycle with ce=1, we=1, addr=0x100, sel=0001, data_o=0xA5A5A5A5. resp_valid 2 cycles after accept, err=0.
- LH addr=0x102, RAM word 0x1234_8001, RD_LAT=1 → ce held 2 cycles, sel=0011. resp_rdata=0xFFFF8001 at accept+3. The same access as LHU returns 0x00008001.
- LB across all 4 offsets of word 0x80_7F_01_FE → results 0xFFFFFF80, 0x0000007F, 0x00000001, 0xFFFFFFFE.
- SW addr=0x102 (misaligned) → mem_ce_o never 1. resp_valid with resp_err=1, resp_rdata=0 at accept+2.
- Back-to-back: req_valid held high with SW then LW to the same address → the second is accepted only after RESP. The LW returns the stored word; req_ready is low throughout both accesses.
